// File: rtl/trig_frame_sync_pkg.sv
// trig_frame_sync_pkg: shared FSM state type, default parameters and SOF decode helpers
package trig_frame_sync_pkg;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  localparam int DEF_NCHAN = 24;
  localparam int DEF_NLANES = 8;
  localparam int DEF_FRAME_LEN = 8;
  localparam int DEF_LOCK_FRAMES = 4;
  localparam int DEF_UNLOCK_MISSES = 3;
  localparam int DEF_ERR_CNT_BITS = 12;
  localparam int MAX_FL = 64;
  function automatic logic is_onehot(input logic [MAX_FL-1:0] v);
    return v != '0 && (v & (v - 64'd1)) == '0;
  endfunction
  function automatic logic [5:0] onehot_index(input logic [MAX_FL-1:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < MAX_FL; i++) if (v[i]) r = 6'(i);
    return r;
  endfunction
endpackage

// File: rtl/trig_frame_sync_sof_lock_fsm.sv
// sof_lock_fsm: per-channel SOF decode and HUNT/VERIFY/LOCKED lock tracker with hysteresis
//  i_clock, i_reset_n (sync, active-low), i_mask (forces HUNT), i_cnt_reset, i_sof (bit 0 earliest)
//  o_locked, o_lock_lost (pulse on LOCKED->HUNT), o_pos (frame bit phase), o_err_cnt, o_sump
//  Error counter built only with TRIG_FRAME_SYNC_ERR_CNT_EN defined.
module sof_lock_fsm
  import trig_frame_sync_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES,
  parameter int UNLOCK_MISSES = DEF_UNLOCK_MISSES,
  parameter int ERR_CNT_BITS = DEF_ERR_CNT_BITS
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_mask,
  input  logic                         i_cnt_reset,
  input  logic [FRAME_LEN-1:0]         i_sof,
  output logic                         o_locked,
  output logic                         o_lock_lost,
  output logic [$clog2(FRAME_LEN)-1:0] o_pos,
  output logic [ERR_CNT_BITS-1:0]      o_err_cnt,
  output logic                         o_sump
);
  localparam int PW = $clog2(FRAME_LEN);
  localparam int CMAX = LOCK_FRAMES > UNLOCK_MISSES ? LOCK_FRAMES : UNLOCK_MISSES;
  localparam int CW = $clog2(CMAX + 1);
  state_t r_state, w_state;
  logic [PW-1:0] r_pos, w_pos;
  logic [CW-1:0] r_cnt, w_cnt, r_miss, w_miss, w_inc;
  logic r_lock_lost, w_lost, w_good, w_match, w_spare;
  logic [5:0] w_idx;
  assign w_good = is_onehot(64'(i_sof));
  assign w_idx = onehot_index(64'(i_sof));
  assign w_match = w_good && w_idx[PW-1:0] == r_pos;
  assign w_inc = r_cnt + 1'b1;
  always_comb begin
    w_state = r_state;
    w_pos = r_pos;
    w_cnt = r_cnt;
    w_miss = r_miss;
    w_lost = 1'b0;
    if (i_mask) begin
      w_state = HUNT;
      w_cnt = '0;
      w_miss = '0;
    end else begin
      case (r_state)
        HUNT: if (w_good) begin
          w_pos = w_idx[PW-1:0];
          w_cnt = CW'(1);
          w_state = LOCK_FRAMES == 1 ? LOCKED : VERIFY;
        end
        VERIFY: if (!w_good) begin
          w_state = HUNT;
          w_cnt = '0;
        end else if (w_match) begin
          w_cnt = w_inc;
          w_state = w_inc == CW'(LOCK_FRAMES) ? LOCKED : VERIFY;
        end else begin
          w_pos = w_idx[PW-1:0];
          w_cnt = CW'(1);
        end
        LOCKED: if (w_match) begin
          w_miss = '0;
        end else if (r_miss == CW'(UNLOCK_MISSES - 1)) begin
          w_state = HUNT;
          w_miss = '0;
          w_cnt = '0;
          w_lost = 1'b1;
        end else begin
          w_miss = r_miss + 1'b1;
        end
        default: w_state = HUNT;
      endcase
    end
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= HUNT;
      r_pos <= '0;
      r_cnt <= '0;
      r_miss <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pos <= w_pos;
      r_cnt <= w_cnt;
      r_miss <= w_miss;
      r_lock_lost <= w_lost;
    end
  end
`ifdef TRIG_FRAME_SYNC_ERR_CNT_EN
  logic [ERR_CNT_BITS-1:0] r_err;
  always_ff @(posedge i_clock) begin
    if (!i_reset_n || i_cnt_reset) r_err <= '0;
    else if (!i_mask && r_state == LOCKED && !w_match && !(&r_err)) r_err <= r_err + 1'b1;
  end
  assign o_err_cnt = r_err;
  assign w_spare = 1'b0;
`else
  assign o_err_cnt = '0;
  assign w_spare = i_cnt_reset;
`endif
  assign o_locked = r_state == LOCKED;
  assign o_lock_lost = r_lock_lost;
  assign o_pos = r_pos;
  assign o_sump = (|(w_idx >> PW)) | w_spare;
endmodule

// File: rtl/trig_frame_sync.sv
// trig_frame_sync: per-VFAT S-bit frame synchroniser, locks on SOF phase and rotates lanes into aligned frames
//  i_clock, i_reset_n (sync, active-low), i_sbit_mask (1 = channel off), i_cnt_reset, i_sof, i_din
//  o_sbits (aligned frames, din packing), o_locked, o_lock_lost, o_err_cnt, o_sump
//  Optional per-channel error counters: TRIG_FRAME_SYNC_ERR_CNT_EN.
module trig_frame_sync
  import trig_frame_sync_pkg::*;
#(
  parameter int NCHAN = DEF_NCHAN,
  parameter int NLANES = DEF_NLANES,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES,
  parameter int UNLOCK_MISSES = DEF_UNLOCK_MISSES,
  parameter int ERR_CNT_BITS = DEF_ERR_CNT_BITS
) (
  input  logic                              i_clock,
  input  logic                              i_reset_n,
  input  logic [NCHAN-1:0]                  i_sbit_mask,
  input  logic                              i_cnt_reset,
  input  logic [NCHAN*FRAME_LEN-1:0]        i_sof,
  input  logic [NCHAN*NLANES*FRAME_LEN-1:0] i_din,
  output logic [NCHAN*NLANES*FRAME_LEN-1:0] o_sbits,
  output logic [NCHAN-1:0]                  o_locked,
  output logic [NCHAN-1:0]                  o_lock_lost,
  output logic [NCHAN*ERR_CNT_BITS-1:0]     o_err_cnt,
  output logic                              o_sump
);
  localparam int PW = $clog2(FRAME_LEN);
  logic [NCHAN*NLANES*FRAME_LEN-1:0] r_prev;
  logic [NCHAN*NLANES-1:0] w_lane_sump;
  logic [NCHAN-1:0] w_fsm_sump;
  logic r_sump;
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_prev <= '0;
    else r_prev <= i_din;
  end
  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    logic [PW-1:0] w_pos;
    sof_lock_fsm #(
      .FRAME_LEN(FRAME_LEN),
      .LOCK_FRAMES(LOCK_FRAMES),
      .UNLOCK_MISSES(UNLOCK_MISSES),
      .ERR_CNT_BITS(ERR_CNT_BITS)
    ) u_fsm (
      .i_clock(i_clock),
      .i_reset_n(i_reset_n),
      .i_mask(i_sbit_mask[c]),
      .i_cnt_reset(i_cnt_reset),
      .i_sof(i_sof[c*FRAME_LEN +: FRAME_LEN]),
      .o_locked(o_locked[c]),
      .o_lock_lost(o_lock_lost[c]),
      .o_pos(w_pos),
      .o_err_cnt(o_err_cnt[c*ERR_CNT_BITS +: ERR_CNT_BITS]),
      .o_sump(w_fsm_sump[c])
    );
    for (genvar l = 0; l < NLANES; l++) begin : g_ln
      localparam int B = (c * NLANES + l) * FRAME_LEN;
      logic [2*FRAME_LEN-1:0] w_pair;
      logic [FRAME_LEN-1:0] r_sbits;
      // low half after the shift is {next[p-1:0], prev[FL-1:p]}
      assign w_pair = {i_din[B +: FRAME_LEN], r_prev[B +: FRAME_LEN]} >> w_pos;
      always_ff @(posedge i_clock) begin
        if (!i_reset_n) r_sbits <= '0;
        else r_sbits <= (o_locked[c] && !i_sbit_mask[c]) ? w_pair[FRAME_LEN-1:0] : '0;
      end
      assign o_sbits[B +: FRAME_LEN] = r_sbits;
      assign w_lane_sump[c*NLANES+l] = |w_pair[2*FRAME_LEN-1:FRAME_LEN];
    end
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_sump <= 1'b0;
    else r_sump <= (|w_lane_sump) | (|w_fsm_sump);
  end
  assign o_sump = r_sump;
endmodule

// File: tb/tb_trig_frame_sync.sv
// tb_trig_frame_sync: directed table-driven bench for trig_frame_sync
module tb_trig_frame_sync;
  localparam int NC = 24, NL = 8, FL = 8, EB = 12;
`ifdef TRIG_FRAME_SYNC_ERR_CNT_EN
  localparam int EN = 1;
`else
  localparam int EN = 0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, cnt_rst, cnt_rst2, locked2, lost2, sump, sump2;
  logic [NC-1:0] mask, locked, lost;
  logic [NC*FL-1:0] sof;
  logic [NC*NL*FL-1:0] din, sbits;
  logic [NC*EB-1:0] err;
  logic [7:0] sof2, din2, sbits2;
  logic [1:0] err2;
  int total = 0, bad = 0, n = 0, last = 0;

  trig_frame_sync dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_sbit_mask(mask), .i_cnt_reset(cnt_rst),
    .i_sof(sof), .i_din(din), .o_sbits(sbits), .o_locked(locked),
    .o_lock_lost(lost), .o_err_cnt(err), .o_sump(sump));

  trig_frame_sync #(.NCHAN(1), .NLANES(1), .UNLOCK_MISSES(8), .ERR_CNT_BITS(2)) dut2 (
    .i_clock(clk), .i_reset_n(rst_n), .i_sbit_mask(1'b0), .i_cnt_reset(cnt_rst2),
    .i_sof(sof2), .i_din(din2), .o_sbits(sbits2), .o_locked(locked2),
    .o_lock_lost(lost2), .o_err_cnt(err2), .o_sump(sump2));

  typedef struct {logic [7:0] sof; logic lk; logic ll; int sbp;} vec_t;
  vec_t tab[31];

  function automatic logic [7:0] word(int m, int c, int l);
    return 8'(m * 37 + c * 11 + l * 5 + 1);
  endfunction

  function automatic logic [7:0] frame(logic [7:0] cur, logic [7:0] nxt, int p);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (i + p < 8) r[i] = cur[i+p];
      else r[i] = nxt[i+p-8];
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_ch(int m, int c, int p);
    logic [63:0] r;
    r = '0;
    if (p >= 0) for (int l = 0; l < NL; l++) r[l*FL +: FL] = frame(word(m - 1, c, l), word(m, c, l), p);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < NL; l++) din[(c*NL+l)*FL +: FL] = word(n, c, l);
    din2 = word(n, 0, 0);
    @(posedge clk);
    #1;
    last = n;
    n++;
  endtask

  initial begin
    tab = '{
      '{8'h08, 1'b0, 1'b0, -1}, '{8'h08, 1'b0, 1'b0, -1}, '{8'h08, 1'b0, 1'b0, -1},
      '{8'h08, 1'b1, 1'b0, -1}, '{8'h08, 1'b1, 1'b0, 3},  '{8'h00, 1'b1, 1'b0, 3},
      '{8'h00, 1'b1, 1'b0, 3},  '{8'h08, 1'b1, 1'b0, 3},  '{8'h00, 1'b1, 1'b0, 3},
      '{8'h00, 1'b1, 1'b0, 3},  '{8'h00, 1'b0, 1'b1, 3},  '{8'h00, 1'b0, 1'b0, -1},
      '{8'h08, 1'b0, 1'b0, -1}, '{8'h08, 1'b0, 1'b0, -1}, '{8'h20, 1'b0, 1'b0, -1},
      '{8'h20, 1'b0, 1'b0, -1}, '{8'h20, 1'b0, 1'b0, -1}, '{8'h20, 1'b1, 1'b0, -1},
      '{8'h20, 1'b1, 1'b0, 5},  '{8'h20, 1'b1, 1'b0, 5},  '{8'h00, 1'b1, 1'b0, 5},
      '{8'h00, 1'b1, 1'b0, 5},  '{8'h00, 1'b0, 1'b1, 5},  '{8'h20, 1'b0, 1'b0, -1},
      '{8'h20, 1'b0, 1'b0, -1}, '{8'h09, 1'b0, 1'b0, -1}, '{8'h20, 1'b0, 1'b0, -1},
      '{8'h20, 1'b0, 1'b0, -1}, '{8'h20, 1'b0, 1'b0, -1}, '{8'h20, 1'b1, 1'b0, -1},
      '{8'h20, 1'b1, 1'b0, 5}
    };
    rst_n = 1'b0; mask = '0; cnt_rst = 1'b0; cnt_rst2 = 1'b0; sof = '0; sof2 = '0;
    din = '0; din2 = '0;
    step();
    step();
    chk("rst_locked", 64'(locked), 0);
    chk("rst_lost", 64'(lost), 0);
    chk("rst_sbits", 64'(|sbits), 0);
    chk("rst_err", 64'(|err), 0);
    chk("rst_sump", 64'(sump), 0);
    chk("rst_dut2", {58'd0, locked2, lost2, err2, |sbits2, sump2}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      sof = '0;
      sof[7:0] = tab[i].sof;
      step();
      chk($sformatf("row%0d_locked", i), 64'(locked[0]), 64'(tab[i].lk));
      chk($sformatf("row%0d_lost", i), 64'(lost[0]), 64'(tab[i].ll));
      chk($sformatf("row%0d_sbits", i), sbits[63:0], exp_ch(last, 0, tab[i].sbp));
    end
    chk("others_idle", 64'(locked[NC-1:1]), 0);
    rst_n = 1'b0;
    for (int c = 0; c < NC; c++) sof[c*FL +: FL] = 8'(1 << (c % 8));
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("all_not_yet", 64'(locked), 0);
    step();
    chk("all_locked", 64'(locked), 64'(24'hffffff));
    step();
    for (int c = 0; c < NC; c++) chk($sformatf("all_sbits_ch%0d", c), sbits[c*64 +: 64], exp_ch(last, c, c % 8));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_locked", 64'(locked), 0);
    chk("midrst_lost", 64'(lost), 0);
    chk("midrst_sbits", 64'(|sbits), 0);
    step();
    chk("postrst_lost", 64'(lost), 0);
    repeat (2) step();
    chk("relock_not_yet", 64'(locked), 0);
    step();
    chk("relock", 64'(locked), 64'(24'hffffff));
    mask[5] = 1'b1;
    step();
    chk("mask_locked", 64'(locked), 64'(24'hffffdf));
    chk("mask_sbits5", sbits[5*64 +: 64], 0);
    chk("mask_sbits4", sbits[4*64 +: 64], exp_ch(last, 4, 4));
    chk("mask_lost", 64'(lost), 0);
    step();
    chk("mask_hold", 64'(locked), 64'(24'hffffdf));
    mask[5] = 1'b0;
    repeat (3) step();
    chk("unmask_not_yet", 64'(locked[5]), 0);
    step();
    chk("unmask_relock", 64'(locked[5]), 1);
    step();
    chk("unmask_sbits5", sbits[5*64 +: 64], exp_ch(last, 5, 5));
    sof2 = 8'h08;
    repeat (4) step();
    chk("e_locked", 64'(locked2), 1);
    sof2 = 8'h00;
    repeat (2) step();
    chk("e_two", 64'(err2), 64'(EN ? 2 : 0));
    repeat (3) step();
    chk("e_sat", 64'(err2), 64'(EN ? 3 : 0));
    chk("e_still_locked", 64'(locked2), 1);
    sof2 = 8'h08;
    step();
    chk("e_good_hold", 64'(err2), 64'(EN ? 3 : 0));
    sof2 = 8'h00;
    cnt_rst2 = 1'b1;
    step();
    cnt_rst2 = 1'b0;
    chk("e_clr_wins", 64'(err2), 0);
    step();
    chk("e_after_clr", 64'(err2), 64'(EN ? 1 : 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
